// File: rtl/vote_link_pkg.sv
// Shared definitions for the vote-machine serial link: framing constants,
// receiver state encodings and the frame checksum used by both ends.
package vote_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  typedef enum logic [2:0] {
    WAIT_HDR,
    GET_A,
    GET_B,
    GET_C,
    GET_D,
    GET_CHK
  } frame_state_t;

  // Modulo-256 sum of the four count bytes; the transmitter appends this as CHK.
  function automatic logic [7:0] frame_checksum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c,
                                                input logic [7:0] d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling bit FSM,
// one-cycle byte_valid / frame_err strobes.
module uart_rx_byte
  import vote_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_q1;
  logic             rx_s;
  bit_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // NOTE: every register here, including the shift register, is a flop with
  // an async reset and is written only with <=; the synchroniser resets to the
  // idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= BIT_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_q1    <= uart_rx;
      rx_s       <= sync_q1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        BIT_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= BIT_START;
        end
        BIT_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? BIT_IDLE : BIT_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= BIT_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BIT_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            state <= BIT_IDLE;
            if (rx_s) begin
              data       <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= BIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vote_tally_rx.sv
// Counting-station receiver: parses six-byte tally frames from the UART link
// and publishes the four candidate counts only when a frame checks out.
module vote_tally_rx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = vote_link_pkg::SYNC_BYTE,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [3:0] votecounta,
  output logic [3:0] votecountb,
  output logic [3:0] votecountc,
  output logic [3:0] votecountd,
  output logic [5:0] total_votes,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       chk_err,
  output logic       timeout_err
);

  import vote_link_pkg::*;

  localparam int              TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int              TO_W           = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST        = TO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]      rx_data;
  logic            rx_byte_valid;
  logic            rx_frame_err;
  frame_state_t    state;
  logic [7:0]      byte_a, byte_b, byte_c, byte_d;
  logic [TO_W-1:0] idle_cnt;
  logic            nibbles_ok;
  logic            chk_ok;
  logic [5:0]      total_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .data      (rx_data),
    .byte_valid(rx_byte_valid),
    .frame_err (rx_frame_err)
  );

  // Evaluated while rx_data holds the CHK byte; A..D are already captured.
  assign nibbles_ok = ~|{byte_a[7:4], byte_b[7:4], byte_c[7:4], byte_d[7:4]};
  assign chk_ok     = nibbles_ok && (frame_checksum(byte_a, byte_b, byte_c, byte_d) == rx_data);
  assign total_next = 6'(byte_a[3:0]) + 6'(byte_b[3:0]) + 6'(byte_c[3:0]) + 6'(byte_d[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_HDR;
      byte_a      <= '0;
      byte_b      <= '0;
      byte_c      <= '0;
      byte_d      <= '0;
      idle_cnt    <= '0;
      votecounta  <= '0;
      votecountb  <= '0;
      votecountc  <= '0;
      votecountd  <= '0;
      total_votes <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
      // A framing error outranks a timeout; byte_valid and frame_err never coincide.
      if (rx_frame_err) begin
        frame_err <= 1'b1;
        state     <= WAIT_HDR;
        idle_cnt  <= '0;
      end else if (rx_byte_valid) begin
        idle_cnt <= '0;
        case (state)
          WAIT_HDR: if (rx_data == SYNC_BYTE) state <= GET_A;
          GET_A: begin byte_a <= rx_data; state <= GET_B; end
          GET_B: begin byte_b <= rx_data; state <= GET_C; end
          GET_C: begin byte_c <= rx_data; state <= GET_D; end
          GET_D: begin byte_d <= rx_data; state <= GET_CHK; end
          GET_CHK: begin
            state <= WAIT_HDR;
            if (chk_ok) begin
              votecounta  <= byte_a[3:0];
              votecountb  <= byte_b[3:0];
              votecountc  <= byte_c[3:0];
              votecountd  <= byte_d[3:0];
              total_votes <= total_next;
              frame_valid <= 1'b1;
            end else begin
              chk_err <= 1'b1;
            end
          end
          default: state <= WAIT_HDR;
        endcase
      end else if (state != WAIT_HDR) begin
        if (idle_cnt == TO_LAST) begin
          timeout_err <= 1'b1;
          state       <= WAIT_HDR;
          idle_cnt    <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_tally_rx.sv
// Directed bench for vote_tally_rx: drives UART frames bit by bit and checks
// published counts and error pulses against hand-computed values.
`timescale 1ns/1ps
module tb_vote_tally_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [3:0] votecounta, votecountb, votecountc, votecountd;
  logic [5:0] total_votes;
  logic       frame_valid, frame_err, chk_err, timeout_err;

  int checks = 0;
  int errors = 0;
  int n_fv = 0, n_fe = 0, n_ce = 0, n_to = 0;
  int b_fv, b_fe, b_ce, b_to;
  logic multi_err = 1'b0;

  always #5 clk = ~clk;

  vote_tally_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .votecounta (votecounta),
    .votecountb (votecountb),
    .votecountc (votecountc),
    .votecountd (votecountd),
    .total_votes(total_votes),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .chk_err    (chk_err),
    .timeout_err(timeout_err)
  );

  // Pulse counters, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (frame_valid) n_fv++;
    if (frame_err)   n_fe++;
    if (chk_err)     n_ce++;
    if (timeout_err) n_to++;
    if (int'(frame_err) + int'(chk_err) + int'(timeout_err) > 1) multi_err = 1'b1;
  end

  function automatic logic [21:0] outs();
    return {votecounta, votecountb, votecountc, votecountd, total_votes};
  endfunction

  // Pulse counts since the last snapshot: {frame_valid, frame_err, chk_err, timeout_err}.
  function automatic logic [15:0] deltas();
    return {4'(n_fv - b_fv), 4'(n_fe - b_fe), 4'(n_ce - b_ce), 4'(n_to - b_to)};
  endfunction

  task automatic snapshot();
    b_fv = n_fv; b_fe = n_fe; b_ce = n_ce; b_to = n_to;
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (good_stop) begin
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      // Low across the stop-bit sample point, then back to idle before a new start is sampled.
      uart_rx = 1'b0;
      repeat (CPB / 2 + 6) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB / 2 - 6) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) send_byte(f[47 - 8 * i -: 8]);
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 22'd0 || {frame_valid, frame_err, chk_err, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got outs=%h pulses=%b expected outs=0 pulses=0000",
               outs(), {frame_valid, frame_err, chk_err, timeout_err});
    end
    reset = 1'b0;
    snapshot();
    idle_bits(2);
    checks++;
    if (outs() !== 22'd0 || deltas() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: got outs=%h deltas=%h expected 0/0", outs(), deltas());
    end
  endtask

  task automatic test_valid_frame();
    snapshot();
    send_frame(48'hA5_03_01_00_02_06);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd3, 4'd1, 4'd0, 4'd2, 6'd6}) begin
      errors++;
      $display("FAIL valid_counts: got %h expected %h", outs(), {4'd3, 4'd1, 4'd0, 4'd2, 6'd6});
    end
    checks++;
    if (deltas() !== 16'h1000) begin
      errors++;
      $display("FAIL valid_pulses: got %h expected 1000", deltas());
    end
  endtask

  task automatic test_bad_checksum();
    snapshot();
    send_frame(48'hA5_03_01_00_02_07);
    idle_bits(2);
    checks++;
    if (deltas() !== 16'h0010) begin
      errors++;
      $display("FAIL chk_pulses: got %h expected 0010", deltas());
    end
    checks++;
    if (outs() !== {4'd3, 4'd1, 4'd0, 4'd2, 6'd6}) begin
      errors++;
      $display("FAIL chk_hold: got %h expected %h", outs(), {4'd3, 4'd1, 4'd0, 4'd2, 6'd6});
    end
  endtask

  task automatic test_nibble();
    // Checksum matches (0x13+1+0+2=0x16) but A has a non-zero high nibble.
    snapshot();
    send_frame(48'hA5_13_01_00_02_16);
    idle_bits(2);
    checks++;
    if (deltas() !== 16'h0010 || outs() !== {4'd3, 4'd1, 4'd0, 4'd2, 6'd6}) begin
      errors++;
      $display("FAIL nibble_check: got deltas=%h outs=%h expected 0010/%h",
               deltas(), outs(), {4'd3, 4'd1, 4'd0, 4'd2, 6'd6});
    end
  endtask

  task automatic test_frame_err();
    snapshot();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01, 1'b0);
    idle_bits(2);
    checks++;
    if (deltas() !== 16'h0100) begin
      errors++;
      $display("FAIL frame_err_pulse: got %h expected 0100", deltas());
    end
    snapshot();
    send_frame(48'hA5_01_01_01_01_04);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd1, 4'd1, 4'd1, 4'd1, 6'd4} || deltas() !== 16'h1000) begin
      errors++;
      $display("FAIL frame_err_recover: got outs=%h deltas=%h expected %h/1000",
               outs(), deltas(), {4'd1, 4'd1, 4'd1, 4'd1, 6'd4});
    end
  endtask

  task automatic test_timeout();
    snapshot();
    send_byte(8'hA5);
    send_byte(8'h02);
    idle_bits(TOB + 1);
    checks++;
    if (deltas() !== 16'h0001) begin
      errors++;
      $display("FAIL timeout_pulse: got %h expected 0001", deltas());
    end
    snapshot();
    send_frame(48'hA5_04_03_02_01_0A);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd4, 4'd3, 4'd2, 4'd1, 6'd10} || deltas() !== 16'h1000) begin
      errors++;
      $display("FAIL timeout_recover: got outs=%h deltas=%h expected %h/1000",
               outs(), deltas(), {4'd4, 4'd3, 4'd2, 4'd1, 6'd10});
    end
  endtask

  task automatic test_glitch_garbage();
    snapshot();
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(3);
    checks++;
    if (deltas() !== 16'h0000 || outs() !== {4'd4, 4'd3, 4'd2, 4'd1, 6'd10}) begin
      errors++;
      $display("FAIL glitch: got deltas=%h outs=%h expected 0000/%h",
               deltas(), outs(), {4'd4, 4'd3, 4'd2, 4'd1, 6'd10});
    end
    snapshot();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(48'hA5_0F_0F_0F_0F_3C);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd15, 4'd15, 4'd15, 4'd15, 6'd60} || deltas() !== 16'h1000) begin
      errors++;
      $display("FAIL garbage_then_max: got outs=%h deltas=%h expected %h/1000",
               outs(), deltas(), {4'd15, 4'd15, 4'd15, 4'd15, 6'd60});
    end
  endtask

  task automatic test_reset_mid_frame();
    snapshot();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h02);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h expected 0", outs());
    end
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    reset   = 1'b0;
    idle_bits(2);
    send_frame(48'hA5_02_02_02_02_08);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd2, 4'd2, 4'd2, 4'd2, 6'd8} || deltas() !== 16'h1000) begin
      errors++;
      $display("FAIL after_reset_frame: got outs=%h deltas=%h expected %h/1000",
               outs(), deltas(), {4'd2, 4'd2, 4'd2, 4'd2, 6'd8});
    end
  endtask

  task automatic test_back_to_back();
    snapshot();
    send_frame(48'hA5_01_02_03_04_0A);
    send_frame(48'hA5_05_06_07_08_1A);
    idle_bits(2);
    checks++;
    if (outs() !== {4'd5, 4'd6, 4'd7, 4'd8, 6'd26} || deltas() !== 16'h2000) begin
      errors++;
      $display("FAIL back_to_back: got outs=%h deltas=%h expected %h/2000",
               outs(), deltas(), {4'd5, 4'd6, 4'd7, 4'd8, 6'd26});
    end
  endtask

  task automatic test_single_error_per_cycle();
    checks++;
    if (multi_err !== 1'b0) begin
      errors++;
      $display("FAIL one_error_per_cycle: got %b expected 0", multi_err);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_nibble();
    test_frame_err();
    test_timeout();
    test_glitch_garbage();
    test_reset_mid_frame();
    test_back_to_back();
    test_single_error_per_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
